// File: rtl/ring_decoder_chk_if.sv
// Bus between a one-hot ring counter and its receive-side decoder/checker.
// The producer side drives ring_in/valid_in; the checker drives all status.
interface ring_decoder_chk_if #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 8,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             valid_in;
    logic [IDX_W-1:0] index_out;
    logic             index_valid;
    logic             locked;
    logic             lap_pulse;
    logic [LAP_W-1:0] lap_count;
    logic             err_onehot;
    logic             err_seq;
    logic [ERR_W-1:0] err_count;

    modport master (
        output ring_in, valid_in,
        input  index_out, index_valid, locked, lap_pulse, lap_count,
               err_onehot, err_seq, err_count
    );

    modport slave (
        input  ring_in, valid_in,
        output index_out, index_valid, locked, lap_pulse, lap_count,
               err_onehot, err_seq, err_count
    );
endinterface

// File: rtl/ring_decoder_chk.sv
// Receive-side decoder/monitor for a one-hot ring counter.
// Decodes the hot bit to a binary index, verifies each qualified sample is
// one-hot and the rotate-left successor of the previous one, counts laps
// (MSB -> bit0 wraps) and counts errors with saturation. All outputs are
// registered: a response appears one clock after the sampling edge.
module ring_decoder_chk #(
    parameter int WIDTH = 4,
    parameter int LAP_W = 8,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              set,
    ring_decoder_chk_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [LAP_W-1:0] lap_q, lap_n;
    logic [ERR_W-1:0] err_q, err_n;
    logic             iv_q, iv_n;
    logic             lp_q, lp_n;
    logic             eoh_q, eoh_n;
    logic             es_q, es_n;

    logic             is_onehot;
    logic [IDX_W-1:0] hot_idx;
    logic [WIDTH-1:0] ring_rotl;

    // Sample classification: one-hot test, hot-bit position and successor.
    // For a one-hot value, x & (x-1) clears the only set bit.
    always_comb begin
        is_onehot = (bus.ring_in != '0) &&
                    ((bus.ring_in & (bus.ring_in - WIDTH'(1))) == '0);
        hot_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) hot_idx = IDX_W'(i);
        end
        ring_rotl = {bus.ring_in[WIDTH-2:0], bus.ring_in[WIDTH-1]};
    end

    // Lock FSM next-state plus next values of every registered output.
    // Pulses default low so idle cycles clear them; counters/index hold.
    always_comb begin
        state_n = state_q;
        exp_n   = exp_q;
        idx_n   = idx_q;
        lap_n   = lap_q;
        err_n   = err_q;
        iv_n    = 1'b0;
        lp_n    = 1'b0;
        eoh_n   = 1'b0;
        es_n    = 1'b0;
        if (bus.valid_in) begin
            if (!is_onehot) begin
                eoh_n   = 1'b1;
                state_n = UNLOCKED;
            end else begin
                idx_n = hot_idx;
                iv_n  = 1'b1;
                case (state_q)
                    UNLOCKED: begin
                        // Any valid one-hot sample seeds the sequence; it is
                        // never itself counted as a lap.
                        state_n = LOCKED;
                        exp_n   = ring_rotl;
                        lap_n   = '0;
                    end
                    LOCKED: begin
                        if (bus.ring_in == exp_q) begin
                            exp_n = ring_rotl;
                            if (bus.ring_in[0]) begin
                                lp_n  = 1'b1;
                                lap_n = lap_q + LAP_W'(1);
                            end
                        end else begin
                            // Wrong successor drops lock; the following
                            // valid sample relocks from scratch.
                            es_n    = 1'b1;
                            state_n = UNLOCKED;
                        end
                    end
                    default: state_n = UNLOCKED;
                endcase
            end
            if ((eoh_n || es_n) && (err_q != '1)) begin
                err_n = err_q + ERR_W'(1);
            end
        end
    end

    // State and output registers; set overrides any sample on the same edge.
    always_ff @(posedge clk) begin
        if (set) begin
            state_q <= UNLOCKED;
            exp_q   <= '0;
            idx_q   <= '0;
            lap_q   <= '0;
            err_q   <= '0;
            iv_q    <= 1'b0;
            lp_q    <= 1'b0;
            eoh_q   <= 1'b0;
            es_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            exp_q   <= exp_n;
            idx_q   <= idx_n;
            lap_q   <= lap_n;
            err_q   <= err_n;
            iv_q    <= iv_n;
            lp_q    <= lp_n;
            eoh_q   <= eoh_n;
            es_q    <= es_n;
        end
    end

    // Drive the status side of the bus straight from the registers.
    always_comb begin
        bus.index_out   = idx_q;
        bus.index_valid = iv_q;
        bus.locked      = (state_q == LOCKED);
        bus.lap_pulse   = lp_q;
        bus.lap_count   = lap_q;
        bus.err_onehot  = eoh_q;
        bus.err_seq     = es_q;
        bus.err_count   = err_q;
    end
endmodule

// File: tb/tb_ring_decoder_chk.sv
// Self-checking bench for ring_decoder_chk (WIDTH=4, LAP_W=8, ERR_W=8).
// The reference model tracks the ring as an integer position and the expected
// successor as (pos+1) mod WIDTH, with counters as plain ints.
module tb_ring_decoder_chk;
    localparam int WIDTH = 4;
    localparam int LAP_W = 8;
    localparam int ERR_W = 8;
    localparam int IDX_W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic set = 1'b1;

    always #5 clk = ~clk;

    ring_decoder_chk_if #(.WIDTH(WIDTH), .LAP_W(LAP_W), .ERR_W(ERR_W)) bus ();

    ring_decoder_chk #(.WIDTH(WIDTH), .LAP_W(LAP_W), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .set (set),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_locked = 0;
    int m_next   = 0;
    int m_idx    = 0;
    int m_lap    = 0;
    int m_err    = 0;
    bit m_iv = 0, m_lp = 0, m_eoh = 0, m_es = 0;

    function automatic logic [WIDTH-1:0] hot(input int p);
        logic [WIDTH-1:0] x;
        x    = '0;
        x[p] = 1'b1;
        return x;
    endfunction

    // Apply one cycle of stimulus, then advance the model for that edge.
    task automatic drive(input logic [WIDTH-1:0] r, input logic v, input logic s);
        int ones, pos;
        @(negedge clk);
        bus.ring_in  = r;
        bus.valid_in = v;
        set          = s;
        @(posedge clk);
        m_iv = 0; m_lp = 0; m_eoh = 0; m_es = 0;
        if (s) begin
            m_locked = 0; m_next = 0; m_idx = 0; m_lap = 0; m_err = 0;
        end else if (v) begin
            ones = 0; pos = 0;
            for (int i = 0; i < WIDTH; i++) if (r[i]) begin ones++; pos = i; end
            if (ones != 1) begin
                m_eoh = 1; m_locked = 0;
            end else begin
                m_idx = pos; m_iv = 1;
                if (!m_locked) begin
                    m_locked = 1; m_next = (pos + 1) % WIDTH; m_lap = 0;
                end else if (pos == m_next) begin
                    m_next = (pos + 1) % WIDTH;
                    if (pos == 0) begin m_lp = 1; m_lap = (m_lap + 1) % (1 << LAP_W); end
                end else begin
                    m_es = 1; m_locked = 0;
                end
            end
            if ((m_eoh || m_es) && m_err < (1 << ERR_W) - 1) m_err++;
        end
        #1;
    endtask

    task automatic test_reset();
        drive('0, 1'b0, 1'b1);
        total++;
        if ({bus.index_out, bus.index_valid, bus.locked, bus.lap_pulse, bus.lap_count,
             bus.err_onehot, bus.err_seq, bus.err_count} !== '0) begin
            bad++;
            $display("FAIL reset outputs got idx=%0d iv=%b lk=%b lp=%b lap=%0d eoh=%b es=%b err=%0d want all 0",
                     bus.index_out, bus.index_valid, bus.locked, bus.lap_pulse, bus.lap_count,
                     bus.err_onehot, bus.err_seq, bus.err_count);
        end
    endtask

    task automatic test_basic_lap();
        int want_idx[5] = '{0, 1, 2, 3, 0};
        int laps = 0;
        drive('0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(hot(want_idx[k]), 1'b1, 1'b0);
            total++;
            if (bus.index_out !== IDX_W'(want_idx[k]) || bus.index_valid !== 1'b1 || bus.locked !== 1'b1) begin
                bad++;
                $display("FAIL basic step%0d got idx=%0d iv=%b lk=%b want idx=%0d iv=1 lk=1",
                         k, bus.index_out, bus.index_valid, bus.locked, want_idx[k]);
            end
            if (bus.lap_pulse === 1'b1) laps++;
        end
        total++;
        if (laps != 1 || bus.lap_count !== LAP_W'(1)) begin
            bad++;
            $display("FAIL basic lap got pulses=%0d count=%0d want 1/1", laps, bus.lap_count);
        end
    endtask

    task automatic test_onehot_err();
        drive('0, 1'b0, 1'b1);
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0110, 1'b1, 1'b0);
        total++;
        if (bus.err_onehot !== 1'b1 || bus.err_seq !== 1'b0 || bus.locked !== 1'b0 ||
            bus.err_count !== ERR_W'(1) || bus.index_valid !== 1'b0 || bus.index_out !== IDX_W'(1)) begin
            bad++;
            $display("FAIL onehot_err got eoh=%b es=%b lk=%b err=%0d iv=%b idx=%0d want 1 0 0 1 0 1",
                     bus.err_onehot, bus.err_seq, bus.locked, bus.err_count, bus.index_valid, bus.index_out);
        end
        drive(4'b0100, 1'b1, 1'b0);
        total++;
        if (bus.err_onehot !== 1'b0 || bus.locked !== 1'b1 || bus.index_out !== IDX_W'(2) ||
            bus.err_count !== ERR_W'(1) || bus.lap_count !== '0) begin
            bad++;
            $display("FAIL onehot_relock got eoh=%b lk=%b idx=%0d err=%0d lap=%0d want 0 1 2 1 0",
                     bus.err_onehot, bus.locked, bus.index_out, bus.err_count, bus.lap_count);
        end
        drive(4'b0000, 1'b1, 1'b0);
        total++;
        if (bus.err_onehot !== 1'b1 || bus.err_count !== ERR_W'(2) || bus.locked !== 1'b0) begin
            bad++;
            $display("FAIL zero_sample got eoh=%b err=%0d lk=%b want 1 2 0",
                     bus.err_onehot, bus.err_count, bus.locked);
        end
    endtask

    task automatic test_seq_err();
        drive('0, 1'b0, 1'b1);
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b1000, 1'b1, 1'b0);
        total++;
        if (bus.err_seq !== 1'b1 || bus.err_onehot !== 1'b0 || bus.locked !== 1'b0 ||
            bus.err_count !== ERR_W'(1) || bus.index_out !== IDX_W'(3) || bus.index_valid !== 1'b1) begin
            bad++;
            $display("FAIL seq_err got es=%b eoh=%b lk=%b err=%0d idx=%0d iv=%b want 1 0 0 1 3 1",
                     bus.err_seq, bus.err_onehot, bus.locked, bus.err_count, bus.index_out, bus.index_valid);
        end
        drive(4'b0001, 1'b1, 1'b0);
        total++;
        if (bus.err_seq !== 1'b0 || bus.locked !== 1'b1 || bus.lap_pulse !== 1'b0 || bus.lap_count !== '0) begin
            bad++;
            $display("FAIL seq_relock got es=%b lk=%b lp=%b lap=%0d want 0 1 0 0",
                     bus.err_seq, bus.locked, bus.lap_pulse, bus.lap_count);
        end
    endtask

    task automatic test_gaps();
        drive('0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            drive(hot(k % WIDTH), 1'b1, 1'b0);
            drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
            total++;
            if (bus.index_valid !== 1'b0 || bus.err_onehot !== 1'b0 || bus.err_seq !== 1'b0 ||
                bus.locked !== 1'b1 || bus.index_out !== IDX_W'(k % WIDTH) || bus.err_count !== '0 ||
                bus.lap_pulse !== 1'b0) begin
                bad++;
                $display("FAIL gap%0d got iv=%b eoh=%b es=%b lk=%b idx=%0d err=%0d lp=%b want 0 0 0 1 %0d 0 0",
                         k, bus.index_valid, bus.err_onehot, bus.err_seq, bus.locked, bus.index_out,
                         bus.err_count, bus.lap_pulse, k % WIDTH);
            end
        end
        total++;
        if (bus.lap_count !== LAP_W'(2)) begin
            bad++;
            $display("FAIL gap_laps got %0d want 2", bus.lap_count);
        end
    endtask

    task automatic test_wrap_saturate();
        drive('0, 1'b0, 1'b1);
        drive(4'b0001, 1'b1, 1'b0);
        for (int k = 1; k <= 260 * WIDTH; k++) drive(hot(k % WIDTH), 1'b1, 1'b0);
        total++;
        if (bus.lap_count !== LAP_W'(4) || bus.err_count !== '0 || bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL lap_wrap got lap=%0d err=%0d lk=%b want 4 0 1",
                     bus.lap_count, bus.err_count, bus.locked);
        end
        drive('0, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            drive(4'b0101, 1'b1, 1'b0);
            if (k == 254) begin
                total++;
                if (bus.err_count !== 8'd255) begin
                    bad++;
                    $display("FAIL err_reach got %0d want 255", bus.err_count);
                end
            end
        end
        total++;
        if (bus.err_count !== 8'd255 || bus.err_onehot !== 1'b1) begin
            bad++;
            $display("FAIL err_sat got err=%0d eoh=%b want 255 1", bus.err_count, bus.err_onehot);
        end
    endtask

    task automatic test_set_priority();
        drive('0, 1'b0, 1'b1);
        drive(4'b0001, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0011, 1'b1, 1'b0);
        drive(4'b0100, 1'b1, 1'b1);
        total++;
        if ({bus.index_out, bus.index_valid, bus.locked, bus.lap_pulse, bus.lap_count,
             bus.err_onehot, bus.err_seq, bus.err_count} !== '0) begin
            bad++;
            $display("FAIL set_prio got idx=%0d iv=%b lk=%b err=%0d want all 0",
                     bus.index_out, bus.index_valid, bus.locked, bus.err_count);
        end
        drive(4'b1000, 1'b1, 1'b0);
        total++;
        if (bus.locked !== 1'b1 || bus.index_out !== IDX_W'(3) || bus.err_seq !== 1'b0 || bus.lap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL set_relock got lk=%b idx=%0d es=%b lp=%b want 1 3 0 0",
                     bus.locked, bus.index_out, bus.err_seq, bus.lap_pulse);
        end
    endtask

    task automatic test_random();
        int kind;
        logic [WIDTH-1:0] r;
        logic v, s;
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 99);
            s = 1'b0; v = 1'b1;
            if (kind < 60)      r = m_locked ? hot(m_next) : hot($urandom_range(0, WIDTH - 1));
            else if (kind < 72) begin r = 4'($urandom_range(0, 15)); v = 1'b0; end
            else if (kind < 82) r = hot($urandom_range(0, WIDTH - 1));
            else if (kind < 96) r = 4'($urandom_range(0, 15));
            else begin r = 4'($urandom_range(0, 15)); s = 1'b1; end
            drive(r, v, s);
            total++;
            if (bus.index_out !== IDX_W'(m_idx) || bus.index_valid !== m_iv || bus.locked !== m_locked ||
                bus.lap_pulse !== m_lp || bus.lap_count !== LAP_W'(m_lap) || bus.err_onehot !== m_eoh ||
                bus.err_seq !== m_es || bus.err_count !== ERR_W'(m_err)) begin
                bad++;
                $display("FAIL rand%0d in=%b v=%b s=%b got idx=%0d iv=%b lk=%b lp=%b lap=%0d eoh=%b es=%b err=%0d want %0d %b %b %b %0d %b %b %0d",
                         n, r, v, s, bus.index_out, bus.index_valid, bus.locked, bus.lap_pulse,
                         bus.lap_count, bus.err_onehot, bus.err_seq, bus.err_count,
                         m_idx, m_iv, m_locked, m_lp, m_lap, m_eoh, m_es, m_err);
            end
            total++;
            if (bus.err_onehot === 1'b1 && bus.err_seq === 1'b1) begin
                bad++;
                $display("FAIL rand%0d both error pulses high got eoh=1 es=1 want at most one", n);
            end
        end
    endtask

    initial begin
        bus.ring_in  = '0;
        bus.valid_in = 1'b0;
        test_reset();
        test_basic_lap();
        test_onehot_err();
        test_seq_err();
        test_gaps();
        test_wrap_saturate();
        test_set_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
